// File: rtl/multiport_register_file_pkg.sv
// Shared constants and types for the multiport register file.
package multiport_register_file_pkg;
  localparam int RF_XLEN     = 32;
  localparam int RF_NUM_REGS = 32;
  localparam int REG_ZERO    = 0;

  typedef logic [RF_XLEN-1:0] rv_reg_t;

  typedef struct packed {
    logic    en;
    logic [4:0] addr;
    rv_reg_t value;
  } reg_write_control_t;

  typedef enum logic {CLEARING = 1'b0, READY = 1'b1} rf_state_e;
endpackage

// File: rtl/multiport_register_file_read_port.sv
// One registered read port: captures an address, bypasses same-cycle writes,
// and keeps a stalled operand coherent with writes to its held address.
module regfile_read_port #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clearing,
  input  logic            rd_enable,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            wr_eff,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_value,
  output logic [XLEN-1:0] rd_val
);
  logic [AW-1:0]   held_addr_d, held_addr_q;
  logic [XLEN-1:0] rd_val_d, rd_val_q;

  // wr_eff already excludes dropped writes, so an address match implies a live register.
  always_comb begin
    held_addr_d = held_addr_q;
    rd_val_d    = rd_val_q;
    if (clearing) begin
      rd_val_d = '0;
    end else if (rd_enable) begin
      held_addr_d = rd_addr;
      rd_val_d    = (wr_eff && wr_addr == rd_addr) ? wr_value : mem_rdata;
    end else if (wr_eff && wr_addr == held_addr_q) begin
      rd_val_d = wr_value;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      held_addr_q <= '0;
      rd_val_q    <= '0;
    end else begin
      held_addr_q <= held_addr_d;
      rd_val_q    <= rd_val_d;
    end
  end

  assign rd_val = rd_val_q;
endmodule

// File: rtl/multiport_register_file.sv
// Register file with N registered read ports, one write port, write-first bypass
// and a hardware clear sequence that gates `ready` after reset.
module multiport_register_file
  import multiport_register_file_pkg::*;
#(
  parameter int XLEN           = RF_XLEN,
  parameter int NUM_REGS       = RF_NUM_REGS,
  parameter int NUM_READ_PORTS = 2,
  parameter int ZERO_REG       = 1,
  localparam int AW            = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_READ_PORTS-1:0][AW-1:0]    rd_addr,
  input  logic [NUM_READ_PORTS-1:0]            rd_enable,
  input  logic                                 wr_enable,
  input  logic [AW-1:0]                        wr_addr,
  input  logic [XLEN-1:0]                      wr_value,
  output logic [NUM_READ_PORTS-1:0][XLEN-1:0]  rd_val,
  output logic                                 ready
);
  localparam logic [AW:0]   NREGS_W  = (AW+1)'(NUM_REGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  rf_state_e       state_d, state_q;
  logic [AW-1:0]   clear_idx_d, clear_idx_q;
  logic            ready_d, ready_q;
  logic [XLEN-1:0] mem_q [NUM_REGS];

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic            wr_eff;
  logic            clearing;
  logic [NUM_READ_PORTS-1:0][XLEN-1:0] port_rdata;

  // Address is backed by storage and not the hard-wired zero register.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && !(ZERO_REG != 0 && a == AW'(REG_ZERO));
  endfunction

  assign clearing = (state_q == CLEARING);
  assign wr_eff   = !clearing && wr_enable && addr_live(wr_addr);

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    ready_d     = ready_q;
    mem_we      = wr_eff;
    mem_waddr   = wr_addr;
    mem_wdata   = wr_value;
    if (clearing) begin
      mem_we      = 1'b1;
      mem_waddr   = clear_idx_q;
      mem_wdata   = '0;
      clear_idx_d = clear_idx_q + 1'b1;
      if (clear_idx_q == LAST_IDX) begin
        state_d = READY;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= CLEARING;
      clear_idx_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      ready_q     <= ready_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    assign port_rdata[p] = addr_live(rd_addr[p]) ? mem_q[rd_addr[p]] : '0;

    regfile_read_port #(.XLEN(XLEN), .AW(AW)) u_port (
      .clock     (clock),
      .reset     (reset),
      .clearing  (clearing),
      .rd_enable (rd_enable[p]),
      .rd_addr   (rd_addr[p]),
      .mem_rdata (port_rdata[p]),
      .wr_eff    (wr_eff),
      .wr_addr   (wr_addr),
      .wr_value  (wr_value),
      .rd_val    (rd_val[p])
    );
  end

  assign ready = ready_q;
endmodule

// File: tb/tb_multiport_register_file.sv
module tb_multiport_register_file;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic            rst_a;
  logic [1:0][4:0] a_addr;
  logic [1:0]      a_en;
  logic            a_we;
  logic [4:0]      a_waddr;
  logic [31:0]     a_wval;
  logic [1:0][31:0] a_rd;
  logic            a_rdy;

  logic            rst_c;
  logic [2:0][4:0] c_addr;
  logic [2:0]      c_en;
  logic            c_we;
  logic [4:0]      c_waddr;
  logic [31:0]     c_wval;
  logic [2:0][31:0] c_rd;
  logic            c_rdy;

  multiport_register_file #(.XLEN(32), .NUM_REGS(32), .NUM_READ_PORTS(2), .ZERO_REG(1)) u_a (
    .clock(clock), .reset(rst_a), .rd_addr(a_addr), .rd_enable(a_en),
    .wr_enable(a_we), .wr_addr(a_waddr), .wr_value(a_wval), .rd_val(a_rd), .ready(a_rdy)
  );

  multiport_register_file #(.XLEN(32), .NUM_REGS(24), .NUM_READ_PORTS(3), .ZERO_REG(0)) u_c (
    .clock(clock), .reset(rst_c), .rd_addr(c_addr), .rd_enable(c_en),
    .wr_enable(c_we), .wr_addr(c_waddr), .wr_value(c_wval), .rd_val(c_rd), .ready(c_rdy)
  );

  typedef struct {
    int          due;
    int          dut;
    int          port;
    logic [31:0] val;
    string       name;
  } chk_t;

  chk_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic expect_nx(input int dut, input int port, input logic [31:0] v, input string name);
    chk_t c;
    c.due = cyc + 1; c.dut = dut; c.port = port; c.val = v; c.name = name;
    sb.push_back(c);
  endtask

  function automatic logic [31:0] actual(input int dut, input int port);
    if (dut == 0) return (port < 0) ? {31'b0, a_rdy} : a_rd[port];
    return (port < 0) ? {31'b0, c_rdy} : c_rd[port];
  endfunction

  task automatic check_now(input int dut, input int port, input logic [31:0] v, input string name);
    logic [31:0] got;
    got = actual(dut, port);
    n_tests++;
    if (got !== v) begin
      n_fail++;
      $display("FAIL %s: dut%0d port%0d got %h expected %h (cycle %0d)",
               name, dut, port, got, v, cyc);
    end
  endtask

  always @(negedge clock) begin : mon
    chk_t c;
    logic [31:0] got;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      c = sb.pop_front();
      got = actual(c.dut, c.port);
      n_tests++;
      if (c.due != cyc || got !== c.val) begin
        n_fail++;
        $display("FAIL %s: dut%0d port%0d got %h expected %h (due %0d, cycle %0d)",
                 c.name, c.dut, c.port, got, c.val, c.due, cyc);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    rst_a = 1'b1; a_addr = '0; a_en = '0; a_we = 1'b0; a_waddr = '0; a_wval = '0;
    rst_c = 1'b1; c_addr = '0; c_en = '0; c_we = 1'b0; c_waddr = '0; c_wval = '0;

    expect_nx(0, -1, 32'h0, "a_reset_ready");
    expect_nx(0, 0, 32'h0, "a_reset_rd0");
    expect_nx(0, 1, 32'h0, "a_reset_rd1");
    tick();
    check_now(0, -1, 32'h0, "a_reset_state_ready");
    check_now(0, 0, 32'h0, "a_reset_state_rd0");
    check_now(0, 1, 32'h0, "a_reset_state_rd1");
    rst_a = 1'b0;

    for (int k = 1; k <= 32; k++) begin
      if (k == 3) begin
        a_we = 1'b1; a_waddr = 5'd5; a_wval = 32'hDEAD; a_en = 2'b01; a_addr[0] = 5'd5;
        expect_nx(0, 0, 32'h0, "a_clear_rd_forced");
      end else begin
        a_we = 1'b0; a_en = 2'b00;
      end
      expect_nx(0, -1, 32'(k == 32), "a_clear_ready");
      tick();
    end
    check_now(0, -1, 32'h1, "a_wait_expired_ready");
    a_we = 1'b0;

    for (int r = 0; r < 32; r++) begin
      a_en = 2'b11; a_addr[0] = 5'(r); a_addr[1] = 5'(31 - r);
      expect_nx(0, 0, 32'h0, "a_zero_p0");
      expect_nx(0, 1, 32'h0, "a_zero_p1");
      if (r == 0) expect_nx(0, -1, 32'h1, "a_ready_stays");
      tick();
    end

    a_we = 1'b1; a_waddr = 5'd3; a_wval = 32'h1234; a_en = 2'b01; a_addr[0] = 5'd3;
    expect_nx(0, 0, 32'h1234, "a_bypass_p0");
    expect_nx(0, 1, 32'h0, "a_p1_hold_zero");
    tick();
    a_we = 1'b0; a_en = 2'b10; a_addr[1] = 5'd3;
    expect_nx(0, 1, 32'h1234, "a_p1_read_x3");
    expect_nx(0, 0, 32'h1234, "a_p0_hold_x3");
    tick();

    a_we = 1'b1; a_waddr = 5'd0; a_wval = 32'hFFFF_FFFF; a_en = 2'b11; a_addr[0] = 5'd0; a_addr[1] = 5'd0;
    expect_nx(0, 0, 32'h0, "a_x0_bypass_p0");
    expect_nx(0, 1, 32'h0, "a_x0_bypass_p1");
    tick();
    a_we = 1'b0;
    expect_nx(0, 0, 32'h0, "a_x0_read_p0");
    expect_nx(0, 1, 32'h0, "a_x0_read_p1");
    tick();

    a_we = 1'b1; a_waddr = 5'd7; a_wval = 32'h11; a_en = 2'b00;
    tick();
    a_we = 1'b0; a_en = 2'b10; a_addr[1] = 5'd7;
    expect_nx(0, 1, 32'h11, "a_capture_x7");
    tick();
    a_en = 2'b00; a_addr[1] = 5'd0;
    expect_nx(0, 1, 32'h11, "a_stall_c1");
    tick();
    a_we = 1'b1; a_waddr = 5'd7; a_wval = 32'h22;
    expect_nx(0, 1, 32'h22, "a_stall_write_x7");
    tick();
    a_waddr = 5'd8; a_wval = 32'h99;
    expect_nx(0, 1, 32'h22, "a_stall_unrelated");
    expect_nx(0, 0, 32'h0, "a_p0_stall_x0");
    tick();
    a_we = 1'b0; a_en = 2'b01; a_addr[0] = 5'd8;
    expect_nx(0, 0, 32'h99, "a_read_x8");
    expect_nx(0, 1, 32'h22, "a_p1_still_22");
    tick();

    a_we = 1'b1; a_waddr = 5'd4; a_wval = 32'h55; a_en = 2'b00;
    tick();
    a_we = 1'b0; a_en = 2'b01; a_addr[0] = 5'd4;
    expect_nx(0, 0, 32'h55, "a_read_x4");
    tick();
    a_en = 2'b00; rst_a = 1'b1; a_we = 1'b1; a_waddr = 5'd9; a_wval = 32'h77;
    expect_nx(0, -1, 32'h0, "a_rst2_ready");
    expect_nx(0, 0, 32'h0, "a_rst2_rd0");
    expect_nx(0, 1, 32'h0, "a_rst2_rd1");
    tick();
    rst_a = 1'b0; a_we = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      expect_nx(0, -1, 32'h0, "a_partial_clear");
      tick();
    end
    rst_a = 1'b1;
    expect_nx(0, -1, 32'h0, "a_rst3_ready");
    tick();
    rst_a = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      expect_nx(0, -1, 32'(k == 32), "a_restart_ready");
      tick();
    end
    check_now(0, -1, 32'h1, "a_restart_wait_expired");
    a_en = 2'b11; a_addr[0] = 5'd4; a_addr[1] = 5'd9;
    expect_nx(0, 0, 32'h0, "a_x4_cleared");
    expect_nx(0, 1, 32'h0, "a_x9_cleared");
    tick();
    a_en = 2'b00;

    rst_c = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      expect_nx(1, -1, 32'(k == 24), "c_clear_ready");
      tick();
    end
    check_now(1, -1, 32'h1, "c_wait_expired_ready");
    c_we = 1'b1; c_waddr = 5'd0; c_wval = 32'hFFFF_FFFF;
    tick();
    c_we = 1'b0; c_en = 3'b011; c_addr[0] = 5'd0; c_addr[1] = 5'd0;
    expect_nx(1, 0, 32'hFFFF_FFFF, "c_x0_p0");
    expect_nx(1, 1, 32'hFFFF_FFFF, "c_x0_p1");
    tick();
    c_we = 1'b1; c_waddr = 5'd30; c_wval = 32'hABCD; c_en = 3'b100; c_addr[2] = 5'd30;
    expect_nx(1, 2, 32'h0, "c_x30_no_bypass");
    tick();
    c_we = 1'b0;
    expect_nx(1, 2, 32'h0, "c_x30_read");
    tick();
    c_we = 1'b1; c_waddr = 5'd23; c_wval = 32'h77; c_en = 3'b000;
    tick();
    c_we = 1'b0; c_en = 3'b111; c_addr[0] = 5'd23; c_addr[1] = 5'd23; c_addr[2] = 5'd23;
    for (int p = 0; p < 3; p++) expect_nx(1, p, 32'h77, "c_x23_read");
    tick();
    c_we = 1'b1; c_wval = 32'h88;
    for (int p = 0; p < 3; p++) expect_nx(1, p, 32'h88, "c_x23_bypass");
    tick();
    c_we = 1'b0; c_en = 3'b000;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
